reduction_input_queue: RTL

- Per-port input buffer that sits directly upstream of the reduction tree; one instance per port, PORT_NUM = 6 instances.
- Accepts flits from a link or the injection port under credit-based flow control.
- Holds up to DEPTH flits and presents the head flit to one reduction-tree input with a valid/avail handshake.
- Returns freed buffer slots to the upstream sender as batched credits.

---
 rtl/reduction_input_queue.sv | 126 ++++++++++++
 1 files changed

// File: rtl/reduction_input_queue.sv
// Per-port input buffer feeding one input of the reduction tree.
// First-word fall-through circular FIFO with valid/avail output handshake,
// sticky overflow flag, and batched credit return to the upstream sender
// (periodic, or early once a full queue's worth of slots has been freed).
module reduction_input_queue #(
  parameter int FLIT_SIZE     = 82,
  parameter int DEPTH         = 5,
  parameter int CREDIT_PERIOD = 100,
  parameter int CNT_W         = 3     // 2**CNT_W must exceed DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] in,
  input  logic                 in_valid,
  output logic [FLIT_SIZE-1:0] out,
  output logic                 out_valid,
  input  logic                 out_avail,
  output logic [CNT_W-1:0]     credit_out,
  output logic                 credit_valid,
  output logic [CNT_W-1:0]     count,
  output logic                 overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMR_W = (CREDIT_PERIOD > 1) ? $clog2(CREDIT_PERIOD) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CREDIT_PERIOD - 1);

  logic [FLIT_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [TMR_W-1:0]     timer;
  logic [CNT_W-1:0]     freed;

  logic                 pop;
  logic                 push;
  logic                 full;
  logic                 credit_ret;
  logic [CNT_W-1:0]     freed_plus;
  logic [CNT_W-1:0]     count_next;

  // Pointer advance with explicit wrap, since DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Head is presented straight from registered state: no same-cycle bypass.
  assign out_valid = (count != '0);
  assign out       = mem[rd_ptr];

  // Handshake decode, next occupancy and credit-return decision.
  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    pop        = out_valid & out_avail;
    full       = (count == DEPTH_C);
    push       = in_valid & (~full | pop);
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    freed_plus = freed + CNT_W'(pop);
    credit_ret = ((timer == TMR_LAST) && (freed != '0)) || (freed_plus == DEPTH_C);
  end

  // Flit storage: write the incoming flit at the tail on an accepted push.
  // NOTE: the array is reset so that out reads zero after reset; without that
  // requirement the storage would be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= in;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_next;
      // A flit arriving with no room means upstream overran its credits.
      if (in_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Free-running credit period timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else begin
      timer <= (timer == TMR_LAST) ? '0 : timer + 1'b1;
    end
  end

  // Freed-slot accumulator and one-cycle credit pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freed        <= '0;
      credit_out   <= '0;
      credit_valid <= 1'b0;
    end else if (credit_ret) begin
      credit_valid <= 1'b1;
      credit_out   <= freed_plus;
      freed        <= '0;
    end else begin
      credit_valid <= 1'b0;
      freed        <= freed_plus;
    end
  end

endmodule
